// File: rtl/aes_word_packer.sv
// Packs a 32-bit word stream into a held AES-128 key and plaintext blocks for the AES core; 1 cycle from the 4th word to blk_valid.
// A completing word stalls while an unconsumed block is pending. Optional byte swap of input words: AES_PACK_BSWAP_EN.
module aes_word_packer #(
  parameter int KEY_PERSIST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_is_key,
  output logic [0:127]  blk_in,
  output logic [0:127]  blk_key,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic          key_valid,
  output logic          err_nokey
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state;
  logic [1:0]  key_cnt;
  logic [1:0]  dat_cnt;
  logic [95:0] key_shadow;
  logic [95:0] dat_shadow;
  logic [31:0] word;
  logic        completing;
  logic        accept;
  logic        key_done;
  logic        dat_done;
  logic        key_ok;
  logic        issue;
  logic        handoff;

`ifdef AES_PACK_BSWAP_EN
  assign word = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign word = s_data;
`endif

  assign blk_valid  = (state == ST_FULL);
  assign completing = s_is_key ? (key_cnt == 2'd3) : (dat_cnt == 2'd3);
  assign s_ready    = !(completing && blk_valid && !blk_ready);
  assign accept     = s_valid && s_ready;
  assign key_done   = accept && s_is_key && (key_cnt == 2'd3);
  assign dat_done   = accept && !s_is_key && (dat_cnt == 2'd3);
  // A key finishing alongside the last data word counts as already loaded.
  assign key_ok     = key_valid || key_done;
  assign issue      = dat_done && key_ok;
  assign handoff    = blk_valid && blk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_cnt    <= 2'd0;
      dat_cnt    <= 2'd0;
      key_shadow <= 96'd0;
      dat_shadow <= 96'd0;
    end else if (accept) begin
      if (s_is_key) begin
        key_cnt    <= key_cnt + 2'd1;
        key_shadow <= {key_shadow[63:0], word};
      end else begin
        dat_cnt    <= dat_cnt + 2'd1;
        dat_shadow <= {dat_shadow[63:0], word};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_key   <= '0;
      key_valid <= 1'b0;
    end else if (key_done) begin
      blk_key   <= {key_shadow, word};
      key_valid <= 1'b1;
    end else if ((KEY_PERSIST == 0) && handoff) begin
      key_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      blk_in <= '0;
    end else begin
      if (issue) begin
        blk_in <= {dat_shadow, word};
      end
      case (state)
        ST_EMPTY: if (issue) state <= ST_FULL;
        ST_FULL:  if (blk_ready && !issue) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_nokey <= 1'b0;
    end else begin
      err_nokey <= dat_done && !key_ok;
    end
  end

endmodule

// File: tb/tb_aes_word_packer.sv
// Bench for aes_word_packer: KEY_PERSIST=0 and =1 instances share one stimulus stream and are checked
// each cycle against a word-accumulating reference model, plus vector tables and hand-written sequences.
module tb_aes_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_is_key = 1'b0;
  logic        blk_ready = 1'b1;
  logic [31:0] s_data = 32'd0;

  logic        s_rdy [2];
  logic        bvld  [2];
  logic        kvld  [2];
  logic        errp  [2];
  logic [0:127] bin  [2];
  logic [0:127] bkey [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_word_packer #(.KEY_PERSIST(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_rdy[0]), .s_data(s_data),
    .s_is_key(s_is_key), .blk_in(bin[0]), .blk_key(bkey[0]), .blk_valid(bvld[0]),
    .blk_ready(blk_ready), .key_valid(kvld[0]), .err_nokey(errp[0]));

  aes_word_packer #(.KEY_PERSIST(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_rdy[1]), .s_data(s_data),
    .s_is_key(s_is_key), .blk_in(bin[1]), .blk_key(bkey[1]), .blk_valid(bvld[1]),
    .blk_ready(blk_ready), .key_valid(kvld[1]), .err_nokey(errp[1]));

  // Reference model: words collected per group, committed as whole 128-bit values.
  logic [127:0] kacc [2];
  logic [127:0] dacc [2];
  int           kn   [2];
  int           dn   [2];
  logic [127:0] mkey [2];
  logic [127:0] mblk [2];
  logic         mkv  [2];
  logic         mv   [2];
  logic         me   [2];

  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef AES_PACK_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      kacc[m] = '0; dacc[m] = '0; kn[m] = 0; dn[m] = 0;
      mkey[m] = '0; mblk[m] = '0; mkv[m] = 1'b0; mv[m] = 1'b0; me[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic        last, rdy, acc, kd, dd, ho, kok;
      logic [31:0] w;
      last = s_is_key ? (kn[m] == 3) : (dn[m] == 3);
      rdy  = !(last && mv[m] && !blk_ready);
      chk($sformatf("m%0d s_ready", m), {127'd0, s_rdy[m]}, {127'd0, rdy});
      chk($sformatf("m%0d blk_valid", m), {127'd0, bvld[m]}, {127'd0, mv[m]});
      chk($sformatf("m%0d key_valid", m), {127'd0, kvld[m]}, {127'd0, mkv[m]});
      chk($sformatf("m%0d err_nokey", m), {127'd0, errp[m]}, {127'd0, me[m]});
      chk($sformatf("m%0d blk_in", m), bin[m], mblk[m]);
      chk($sformatf("m%0d blk_key", m), bkey[m], mkey[m]);
      if (rst_n) begin
        acc = s_valid && rdy;
        w   = sw(s_data);
        kd  = acc && s_is_key && (kn[m] == 3);
        dd  = acc && !s_is_key && (dn[m] == 3);
        ho  = mv[m] && blk_ready;
        kok = mkv[m] || kd;
        me[m] = dd && !kok;
        if (dd && kok) begin
          mblk[m] = (dacc[m] << 32) | {96'd0, w};
          mv[m] = 1'b1;
        end else if (ho) begin
          mv[m] = 1'b0;
        end
        if (kd) begin
          mkey[m] = (kacc[m] << 32) | {96'd0, w};
          mkv[m] = 1'b1;
        end else if (m == 0 && ho) begin
          mkv[m] = 1'b0;
        end
        if (acc && s_is_key) begin
          kacc[m] = (kacc[m] << 32) | {96'd0, w};
          kn[m] = (kn[m] + 1) % 4;
        end
        if (acc && !s_is_key) begin
          dacc[m] = (dacc[m] << 32) | {96'd0, w};
          dn[m] = (dn[m] + 1) % 4;
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic k, input logic [31:0] d);
    s_valid = 1'b1; s_is_key = k; s_data = d;
    cyc();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic        v;
    logic        k;
    logic [31:0] d;
    logic        e_rdy;
    logic        e_vld;
    logic        e_kv;
    logic        e_err;
  } vec_t;

  function automatic vec_t vec(input logic v, input logic k, input logic [31:0] d,
                               input logic er, input logic ev, input logic ek, input logic ee);
    vec_t r;
    r.v = v; r.k = k; r.d = d; r.e_rdy = er; r.e_vld = ev; r.e_kv = ek; r.e_err = ee;
    return r;
  endfunction

  logic [31:0] fk [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] fd [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

  initial begin
    vec_t        tbl [14];
    logic [31:0] pd [4];
    logic [31:0] b0 [4];
    logic [31:0] b1 [4];
    logic [31:0] kk [4];
    logic [31:0] dd [4];

    mreset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst m%0d blk_valid", m), {127'd0, bvld[m]}, 128'd0);
      chk($sformatf("rst m%0d key_valid", m), {127'd0, kvld[m]}, 128'd0);
      chk($sformatf("rst m%0d err_nokey", m), {127'd0, errp[m]}, 128'd0);
      chk($sformatf("rst m%0d s_ready", m), {127'd0, s_rdy[m]}, 128'd1);
      chk($sformatf("rst m%0d blk_in", m), bin[m], 128'd0);
      chk($sformatf("rst m%0d blk_key", m), bkey[m], 128'd0);
    end
    rst_n = 1'b1;

    // No key: error pulse and no block; then FIPS-197 key and plaintext.
    for (int j = 0; j < 4; j++) tbl[j] = vec(1'b1, 1'b0, sw(fd[j]), 1'b1, 1'b0, 1'b0, j == 3);
    tbl[4] = vec(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) tbl[5 + j] = vec(1'b1, 1'b1, sw(fk[j]), 1'b1, 1'b0, j == 3, 1'b0);
    for (int j = 0; j < 4; j++) tbl[9 + j] = vec(1'b1, 1'b0, sw(fd[j]), 1'b1, j == 3, 1'b1, 1'b0);
    tbl[13] = vec(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    blk_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s_valid = tbl[i].v; s_is_key = tbl[i].k; s_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d s_ready", i), {127'd0, s_rdy[1]}, {127'd0, tbl[i].e_rdy});
      cyc();
      chk($sformatf("tbl%0d blk_valid", i), {127'd0, bvld[1]}, {127'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d key_valid", i), {127'd0, kvld[1]}, {127'd0, tbl[i].e_kv});
      chk($sformatf("tbl%0d err_nokey", i), {127'd0, errp[1]}, {127'd0, tbl[i].e_err});
      if (i == 12) begin
        chk("fips blk_key", bkey[1], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips blk_in", bin[1], 128'h3243f6a8885a308d313198a2e0370734);
      end
      if (i == 13) chk("p0 key cleared on handoff", {127'd0, kvld[0]}, 128'd0);
    end

    // Second block after a single key load.
    for (int j = 0; j < 4; j++) pd[j] = $urandom;
    for (int j = 0; j < 4; j++) send(1'b0, sw(pd[j]));
    chk("persist1 blk_valid", {127'd0, bvld[1]}, 128'd1);
    chk("persist1 blk_in", bin[1], {pd[0], pd[1], pd[2], pd[3]});
    chk("persist0 err_nokey", {127'd0, errp[0]}, 128'd1);
    chk("persist0 blk_valid", {127'd0, bvld[0]}, 128'd0);
    idle();

    // Backpressure: pending block, three words accepted, fourth stalls.
    for (int j = 0; j < 4; j++) begin b0[j] = $urandom; b1[j] = $urandom; end
    blk_ready = 1'b0;
    for (int j = 0; j < 4; j++) send(1'b0, sw(b0[j]));
    chk("bp first block", bin[1], {b0[0], b0[1], b0[2], b0[3]});
    for (int j = 0; j < 3; j++) begin
      s_valid = 1'b1; s_is_key = 1'b0; s_data = sw(b1[j]);
      #1;
      chk($sformatf("bp word%0d s_ready", j), {127'd0, s_rdy[1]}, 128'd1);
      cyc();
      chk($sformatf("bp word%0d blk_in stable", j), bin[1], {b0[0], b0[1], b0[2], b0[3]});
    end
    s_data = sw(b1[3]);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("bp stall%0d s_ready", j), {127'd0, s_rdy[1]}, 128'd0);
      cyc();
      chk($sformatf("bp stall%0d blk_in", j), bin[1], {b0[0], b0[1], b0[2], b0[3]});
      chk($sformatf("bp stall%0d blk_valid", j), {127'd0, bvld[1]}, 128'd1);
    end
    blk_ready = 1'b1;
    #1;
    chk("bp release s_ready", {127'd0, s_rdy[1]}, 128'd1);
    cyc();
    chk("bp second block", bin[1], {b1[0], b1[1], b1[2], b1[3]});
    chk("bp no bubble", {127'd0, bvld[1]}, 128'd1);
    idle();
    chk("bp consumed", {127'd0, bvld[1]}, 128'd0);

    // Reset after two data words, then interleaved key/data with fresh words.
    send(1'b0, 32'hdeadbeef);
    send(1'b0, 32'hcafef00d);
    s_valid = 1'b0;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("midrst blk_valid", {127'd0, bvld[1]}, 128'd0);
    chk("midrst blk_in", bin[1], 128'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin kk[j] = $urandom; dd[j] = $urandom; end
    for (int j = 0; j < 4; j++) begin
      send(1'b1, sw(kk[j]));
      if (j == 3) chk("ilv key commit", {127'd0, kvld[1]}, 128'd1);
      send(1'b0, sw(dd[j]));
    end
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ilv m%0d blk_valid", m), {127'd0, bvld[m]}, 128'd1);
      chk($sformatf("ilv m%0d blk_key", m), bkey[m], {kk[0], kk[1], kk[2], kk[3]});
      chk($sformatf("ilv m%0d blk_in fresh", m), bin[m], {dd[0], dd[1], dd[2], dd[3]});
    end
    idle();

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin rst_n = 1'b0; mreset(); end
      if (i == 1503) rst_n = 1'b1;
      s_valid   = ($urandom_range(0, 3) != 0);
      s_is_key  = ($urandom_range(0, 9) < 3);
      s_data    = $urandom;
      blk_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_word_packer.md
Name: aes_word_packer

Overview:
- Upstream feeder for the combinational AES-128 core (128-bit plaintext and key in, 128-bit ciphertext out, all MSB-first [0:127]).
- Accepts a 32-bit word stream with valid/ready and assembles 4 key words into a held cipher key and 4 data words into a plaintext block.
- Presents each complete block plus its key to the core with a valid/ready output handshake and holds them stable until the block is consumed.

Parameters:
- KEY_PERSIST, 1, 1: the key is retained across blocks until reloaded; 0: key_valid clears when a block is handed off.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  input word accepted when s_valid && s_ready.
- s_data  input  32  input word.
- s_is_key  input  1  1 = key word, 0 = plaintext word; sampled with s_data.
- blk_in  output  [0:127]  assembled plaintext to the core.
- blk_key  output  [0:127]  committed cipher key to the core.
- blk_valid  output  1  blk_in/blk_key hold a pending block.
- blk_ready  input  1  downstream consumes the block when blk_valid && blk_ready.
- key_valid  output  1  blk_key holds a fully loaded key.
- err_nokey  output  1  one-cycle pulse: plaintext block completed while key_valid=0; block dropped.

Behaviour:
- Reset (async assert, sync release): blk_in=0, blk_key=0, blk_valid=0, key_valid=0, err_nokey=0, both word counters=0, both shadow registers=0. s_ready=1 after reset.
- Word order: first accepted word of a group goes to bits [0:31], second to [32:63], third to [64:95], fourth to [96:127]. Example: 3243f6a8, 885a308d, 313198a2, e0370734 gives 128'h3243f6a8885a308d313198a2e0370734.
- Independent 2-bit counters key_cnt and dat_cnt with independent 96-bit shadows for words 0-2. Interleaving key and data words is legal; each group advances only on its own type.
- Completing word (4th of its type; counter = 3):
  - Key: blk_key <= {key_shadow, s_data}, key_valid <= 1, key_cnt <= 0.
  - Data with key_valid=1: blk_in <= {dat_shadow, s_data}, blk_valid <= 1, dat_cnt <= 0.
  - Data with key_valid=0: word accepted, blk_in unchanged, blk_valid unchanged, err_nokey pulses the next cycle, dat_cnt <= 0.
- Data completing in the same cycle as key completion: the key commits first, so the block issues.
- Output FSM:
  - EMPTY (blk_valid=0) -> FULL on data completion.
  - FULL -> EMPTY on blk_ready, unless a new data completion occurs in the same cycle, in which case it stays FULL with the new blk_in. Back-to-back blocks run with zero bubble.
- s_ready: 0 only when the current word is a completing word (either type) and blk_valid=1 and blk_ready=0. Non-completing words are always accepted. blk_key therefore never changes while a block is pending.
- s_ready is combinational from s_is_key, the counters, blk_valid and blk_ready. There is no combinational path from s_data.
- Handoff: if KEY_PERSIST=0, key_valid <= 0 on blk_valid && blk_ready, unless a key completes in the same cycle (then key_valid=1).
- Latency: 1 cycle from the accepted 4th word to blk_valid=1.
- Core ciphertext is combinational from blk_in/blk_key and is valid while blk_valid=1.
- Reset mid-operation: partial groups discarded and a pending block lost; no error is raised.

Optional Feature:
- Macro AES_PACK_BSWAP_EN.
- Defined: each accepted s_data is byte-reversed before storage, for little-endian sources (word 32'ha8f64332 stored as 3243f6a8). Applies to both key and data words.
- Undefined: words are stored as received.
- err_nokey, handshake and timing are identical in both builds.

Test Plan:
- FIPS-197 load: key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c, then data 3243f6a8, 885a308d, 313198a2, e0370734, blk_ready=1 -> blk_key=2b7e151628aed2a6abf7158809cf4f3c, blk_in=3243f6a8885a308d313198a2e0370734, blk_valid high for one cycle, core out=3925841d02dc09fbdc118597196a0b32.
- No key loaded, 4 data words -> err_nokey single pulse, blk_valid stays 0, dat_cnt back to 0; a following key load then data block issues normally.
- Backpressure: blk_ready=0 with a block pending, stream 3 more data words then the 4th -> first 3 accepted, s_ready=0 on the 4th until blk_ready=1; blk_in stays stable throughout, then the new block loads in the same handoff cycle.
- Interleave key and data words (K0 D0 K1 D1 K2 D2 K3 D3) -> key commits at K3; block issues at D3 with the new key.
- KEY_PERSIST=0: two blocks after one key load -> first issues, second raises err_nokey. KEY_PERSIST=1 -> both issue.
- Assert rst_n low after 2 data words, release, send 4 fresh words -> block equals the fresh words only, with no stale bits.
